// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, pipeline entry type and aging helper for the hazard scoreboard
package hazard_pkg;

  localparam int NSTAGE     = 3;
  localparam int TW         = 2;
  localparam int MD_MUL_LAT = 5;
  localparam int MD_DIV_LAT = 10;

  // Forward select: FWD_GRF reads the register file, any k>0 selects stage k (1=E, 2=M, 3=W)
  localparam int FWD_GRF    = 0;

  typedef struct packed {
    logic          valid;
    logic [4:0]    dst;
    logic [TW-1:0] tnew;
    logic [4:0]    rs;
    logic [4:0]    rt;
  } entry_t;

  function automatic entry_t entry_age(input entry_t e);
    entry_t aged;
    aged = e;
    if (aged.tnew != '0) aged.tnew = aged.tnew - TW'(1);
    return aged;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - nearest-producer lookup for one consumer source register
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NSTAGE = hazard_pkg::NSTAGE,
  parameter int SW     = $clog2(NSTAGE + 1)
) (
  input  logic [4:0]      i_src,
  input  logic            i_use,
  input  logic [TW-1:0]   i_tuse,
  input  logic [NSTAGE:1] i_search,
  input  entry_t          i_entry [1:NSTAGE],
  output logic [SW-1:0]   o_sel,
  output logic            o_stall
);

  logic          w_hit;
  logic [SW-1:0] w_k;
  logic [TW-1:0] w_tnew;

  // Scan from the oldest stage down so the youngest matching producer wins
  always_comb begin
    w_hit  = 1'b0;
    w_k    = '0;
    w_tnew = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (i_search[k] && i_entry[k].valid && (i_entry[k].dst == i_src) && (i_src != 5'd0)) begin
        w_hit  = 1'b1;
        w_k    = SW'(k);
        w_tnew = i_entry[k].tnew;
      end
    end
  end

  assign o_sel   = (w_hit && (w_tnew == '0)) ? w_k : SW'(FWD_GRF);
  assign o_stall = i_use && w_hit && (w_tnew > i_tuse);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tnew/Tuse pipeline scoreboard with forwarding selects, stall and mult/div busy tracking
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE     = hazard_pkg::NSTAGE,
  parameter int TW         = hazard_pkg::TW,
  parameter int MD_MUL_LAT = hazard_pkg::MD_MUL_LAT,
  parameter int MD_DIV_LAT = hazard_pkg::MD_DIV_LAT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [4:0]                    d_rs,
  input  logic [4:0]                    d_rt,
  input  logic                          d_use_rs,
  input  logic                          d_use_rt,
  input  logic [TW-1:0]                 d_tuse_rs,
  input  logic [TW-1:0]                 d_tuse_rt,
  input  logic                          d_wr,
  input  logic [4:0]                    d_dst,
  input  logic [TW-1:0]                 d_tnew,
  input  logic                          d_md,
  input  logic                          md_start,
  input  logic                          md_div,
  input  logic                          flush,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_d,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_d,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_e,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_e,
  output logic                          stall,
  output logic                          md_busy
);

  localparam int MD_MAX = (MD_DIV_LAT > MD_MUL_LAT) ? MD_DIV_LAT : MD_MUL_LAT;
  localparam int MW     = $clog2(MD_MAX + 1);
  localparam logic [NSTAGE:1] D_SEARCH = '1;
  localparam logic [NSTAGE:1] E_SEARCH = {{(NSTAGE-1){1'b1}}, 1'b0};

  entry_t        r_entry [1:NSTAGE];
  logic [MW-1:0] r_md_cnt;
  entry_t        w_issue;
  logic          w_rs_d_stall, w_rt_d_stall, w_rs_e_stall, w_rt_e_stall;

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rs_d (
    .i_src(d_rs), .i_use(d_use_rs), .i_tuse(d_tuse_rs), .i_search(D_SEARCH),
    .i_entry(r_entry), .o_sel(fwd_rs_d), .o_stall(w_rs_d_stall)
  );

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rt_d (
    .i_src(d_rt), .i_use(d_use_rt), .i_tuse(d_tuse_rt), .i_search(D_SEARCH),
    .i_entry(r_entry), .o_sel(fwd_rt_d), .o_stall(w_rt_d_stall)
  );

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rs_e (
    .i_src(r_entry[1].rs), .i_use(1'b0), .i_tuse('0), .i_search(E_SEARCH),
    .i_entry(r_entry), .o_sel(fwd_rs_e), .o_stall(w_rs_e_stall)
  );

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rt_e (
    .i_src(r_entry[1].rt), .i_use(1'b0), .i_tuse('0), .i_search(E_SEARCH),
    .i_entry(r_entry), .o_sel(fwd_rt_e), .o_stall(w_rt_e_stall)
  );

  assign md_busy = (r_md_cnt != '0);

  // E-side lookups have use=0, so their stall terms are constant 0 and merely fold in harmlessly
  assign stall = w_rs_d_stall | w_rt_d_stall | w_rs_e_stall | w_rt_e_stall
               | (d_md && (md_busy || md_start));

  always_comb begin
    w_issue = '0;
    if (!stall && !flush) begin
      w_issue.valid = d_wr && (d_dst != 5'd0);
      w_issue.dst   = d_dst;
      w_issue.tnew  = d_tnew;
      w_issue.rs    = d_rs;
      w_issue.rt    = d_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= NSTAGE; k++) r_entry[k] <= '0;
      r_md_cnt <= '0;
    end else if (en) begin
      r_entry[1] <= w_issue;
      for (int k = 2; k <= NSTAGE; k++) r_entry[k] <= entry_age(r_entry[k-1]);
      if (md_start) r_md_cnt <= md_div ? MW'(MD_DIV_LAT) : MW'(MD_MUL_LAT);
      else if (r_md_cnt != '0) r_md_cnt <= r_md_cnt - MW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n, en;
  logic [4:0] d_rs, d_rt, d_dst;
  logic       d_use_rs, d_use_rt, d_wr, d_md, md_start, md_div, flush;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       stall, md_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr(d_wr), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md(d_md), .md_start(md_start), .md_div(md_div), .flush(flush),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .stall(stall), .md_busy(md_busy)
  );

  // Monitor: compares whatever expectation the stimulus queued for this cycle
  initial begin
    exp_t       e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall, md_busy};
        n_checks++;
        if (got !== e.v) begin
          n_errors++;
          $display("FAIL %s: got rs_d=%0d rt_d=%0d rs_e=%0d rt_e=%0d stall=%0b busy=%0b, expected rs_d=%0d rt_d=%0d rs_e=%0d rt_e=%0d stall=%0b busy=%0b",
                   e.nm, got[9:8], got[7:6], got[5:4], got[3:2], got[1], got[0],
                   e.v[9:8], e.v[7:6], e.v[5:4], e.v[3:2], e.v[1], e.v[0]);
        end
      end
    end
  end

  task automatic expect_o(input string nm, input int rsd, input int rtd, input int rse,
                          input int rte, input bit st, input bit mb);
    exp_t e;
    e.nm = nm;
    e.v  = {2'(rsd), 2'(rtd), 2'(rse), 2'(rte), st, mb};
    q.push_back(e);
  endtask

  task automatic clr();
    d_rs = '0; d_rt = '0; d_use_rs = 0; d_use_rt = 0; d_tuse_rs = '0; d_tuse_rt = '0;
    d_wr = 0; d_dst = '0; d_tnew = '0; d_md = 0; md_start = 0; md_div = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input logic [4:0] dst, input logic [1:0] tnew);
    d_wr = 1; d_dst = dst; d_tnew = tnew;
  endtask

  task automatic rd_rs(input logic [4:0] r, input logic [1:0] tuse);
    d_rs = r; d_use_rs = 1; d_tuse_rs = tuse;
  endtask

  task automatic rd_rt(input logic [4:0] r, input logic [1:0] tuse);
    d_rt = r; d_use_rt = 1; d_tuse_rt = tuse;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion within 100000 time units");
    $fatal(1);
  end

  initial begin
    reset_n = 0; en = 1; clr();
    tick(); tick();
    expect_o("reset", 0, 0, 0, 0, 0, 0);
    reset_n = 1;

    // load-use: lw $8 (tnew 2) then addu $8 (tuse 1)
    tick(); wr(8, 2);              expect_o("lw_issue", 0, 0, 0, 0, 0, 0);
    tick(); rd_rs(8, 1); wr(10, 1); expect_o("lw_use_stall", 0, 0, 0, 0, 1, 0);
    tick(); rd_rs(8, 1); wr(10, 1); expect_o("lw_use_go", 0, 0, 0, 0, 0, 0);
    tick();                        expect_o("lw_fwd_e", 0, 0, 3, 0, 0, 0);
    idle(3);

    // branch: ori $9 (tnew 1) then beq $9 (tuse 0)
    tick(); wr(9, 1);       expect_o("ori_issue", 0, 0, 0, 0, 0, 0);
    tick(); rd_rs(9, 0);    expect_o("beq_stall", 0, 0, 0, 0, 1, 0);
    tick(); rd_rs(9, 0);    expect_o("beq_fwd_d", 2, 0, 0, 0, 0, 0);
    tick();                 expect_o("beq_fwd_e", 0, 0, 3, 0, 0, 0);
    idle(3);

    // $5 in E and W: nearest producer wins
    tick(); wr(5, 0);
    tick();
    tick(); wr(5, 0);
    tick(); rd_rs(5, 1); rd_rt(5, 1); expect_o("nearest", 1, 1, 0, 0, 0, 0);
    idle(3);

    // $0 destination never tracked
    tick(); wr(0, 2);
    tick(); rd_rs(0, 0); rd_rt(0, 0); expect_o("r0_read", 0, 0, 0, 0, 0, 0);
    idle(3);

    // flushed load leaves no hazard; unflushed load does
    tick(); wr(10, 2); flush = 1; expect_o("flush_issue", 0, 0, 0, 0, 0, 0);
    tick(); rd_rs(10, 0);         expect_o("flush_no_stall", 0, 0, 0, 0, 0, 0);
    tick(); wr(10, 2);
    tick(); rd_rs(10, 0);         expect_o("noflush_stall", 0, 0, 0, 0, 1, 0);
    idle(3);

    // en=0 freezes the pipeline while stall stays visible
    tick(); wr(11, 2);
    tick(); en = 0; rd_rs(11, 0); expect_o("frz_stall_a", 0, 0, 0, 0, 1, 0);
    tick(); en = 0; rd_rs(11, 0); expect_o("frz_stall_b", 0, 0, 0, 0, 1, 0);
    tick(); en = 1; rd_rs(11, 0); expect_o("frz_stall_c", 0, 0, 0, 0, 1, 0);
    tick(); rd_rs(11, 0);         expect_o("frz_stall_d", 0, 0, 0, 0, 1, 0);
    tick(); rd_rs(11, 0);         expect_o("frz_fwd", 3, 0, 0, 0, 0, 0);
    idle(3);

    // divide: 10 busy cycles with a waiting mult/div consumer
    tick(); md_start = 1; md_div = 1; d_md = 1; expect_o("div_start", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i <= 10; i++) begin
      tick(); d_md = 1;
      expect_o($sformatf("div_busy_%0d", i), 0, 0, 0, 0, i < 10, i < 10);
    end
    tick();

    // multiply: 5 busy cycles
    tick(); md_start = 1; expect_o("mul_start", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 5; i++) begin
      tick(); expect_o($sformatf("mul_busy_%0d", i), 0, 0, 0, 0, 0, i < 5);
    end

    // divide restarted as multiply: last start wins
    tick(); md_start = 1; md_div = 1;
    tick();
    tick();
    tick(); md_start = 1; expect_o("reload_start", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i <= 5; i++) begin
      tick(); expect_o($sformatf("reload_busy_%0d", i), 0, 0, 0, 0, 0, i < 5);
    end

    // reset during a divide, competing with a new start
    tick(); md_start = 1; md_div = 1;
    tick();
    tick();
    tick();
    tick(); reset_n = 0; md_start = 1; md_div = 1; expect_o("rst_mid_before", 0, 0, 0, 0, 0, 1);
    tick(); reset_n = 1; expect_o("rst_mid_after", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
